voting_machine_n: RTL and testbench

Parametrised N-candidate vote counter, the successor to the fixed 4-candidate voting machine.
- Debounces the candidate buttons and counts exactly one vote per press.
- Rejects simultaneous presses and saturates counts instead of wrapping.
- In display mode, shows any selected candidate's tally, or the grand total, on the LED bus.
- Sits between the raw front-panel buttons and the LED/display driver.

---
 rtl/voting_machine_n.sv | 173 +++++++++++++++++
 tb/tb_voting_machine_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/voting_machine_n.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | voting_machine_n                                                         |
// | N-candidate debounced vote counter with saturation and LED display.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module voting_machine_n #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 10,
  parameter int TOT_W    = CNT_W + 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] cand_buttons,
  input  logic                show_total,
  output logic [CNT_W-1:0]    LEDs,
  output logic                vote_valid,
  output logic [3:0]          vote_cand,
  output logic                invalid_press,
  output logic [NUM_CAND-1:0] sat,
  output logic                busy
);

  localparam int SC_W  = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int IDX_W = $clog2(NUM_CAND);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_COMMIT   = 3'd2,
    S_REJECT   = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CAND-1:0] btn_q;
  logic [NUM_CAND-1:0] arm_mask_q, arm_mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SC_W-1:0]     stable_cnt_q, stable_cnt_d;
  logic                need_rel_q, need_rel_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CAND];
  logic [CNT_W-1:0]    cnt_d [NUM_CAND];
  logic [TOT_W-1:0]    total_q, total_d;
  logic [NUM_CAND-1:0] sat_q, sat_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    leds_q, leds_d;
  logic                vote_valid_q, vote_valid_d;
  logic [3:0]          vote_cand_q, vote_cand_d;
  logic                invalid_q, invalid_d;

  logic                btn_zero;
  logic                btn_multi;
  logic                btn_onehot;
  logic [IDX_W-1:0]    btn_idx;
  logic [CNT_W-1:0]    total_disp;

  assign btn_zero   = (btn_q == '0);
  assign btn_multi  = ((btn_q & (btn_q - NUM_CAND'(1))) != '0);
  assign btn_onehot = !btn_zero && !btn_multi;
  assign total_disp = (|total_q[TOT_W-1:CNT_W]) ? {CNT_W{1'b1}} : total_q[CNT_W-1:0];

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (btn_q[i]) btn_idx = IDX_W'(i);
    end
  end

  // need_rel holds off new presses after reset until the panel has been seen released
  always_comb begin
    state_d      = state_q;
    arm_mask_d   = arm_mask_q;
    idx_d        = idx_q;
    stable_cnt_d = stable_cnt_q;
    need_rel_d   = need_rel_q && !btn_zero;
    case (state_q)
      S_IDLE: begin
        if (mode) begin
          if (!btn_zero) state_d = S_WAIT_REL;
        end else if (!need_rel_q) begin
          if (btn_onehot) begin
            arm_mask_d   = btn_q;
            idx_d        = btn_idx;
            stable_cnt_d = SC_W'(1);
            state_d      = (DEBOUNCE <= 1) ? S_COMMIT : S_ARM;
          end else if (btn_multi) begin
            state_d = S_REJECT;
          end
        end
      end
      S_ARM: begin
        if (mode) begin
          state_d = S_WAIT_REL;
        end else if (btn_zero) begin
          state_d = S_IDLE;
        end else if (btn_q == arm_mask_q) begin
          stable_cnt_d = stable_cnt_q + SC_W'(1);
          if (stable_cnt_d == SC_W'(DEBOUNCE)) state_d = S_COMMIT;
        end else begin
          state_d = S_REJECT;
        end
      end
      S_COMMIT:   state_d = S_WAIT_REL;
      S_REJECT:   state_d = S_WAIT_REL;
      S_WAIT_REL: if (btn_zero) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = cnt_q[i];
    sat_d   = sat_q;
    total_d = total_q;
    if (state_q == S_COMMIT) begin
      if (cnt_q[idx_q] == {CNT_W{1'b1}}) sat_d[idx_q] = 1'b1;
      else                               cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
      if (total_q != {TOT_W{1'b1}}) total_d = total_q + TOT_W'(1);
    end
    vote_valid_d = (state_q == S_COMMIT);
    vote_cand_d  = 4'(idx_q);
    invalid_d    = (state_q == S_REJECT);

    sel_d = sel_q;
    if (mode && btn_onehot) sel_d = btn_idx;
    leds_d = '0;
    if (mode) leds_d = show_total ? total_disp : cnt_q[sel_q];
  end

  always_ff @(posedge clk) begin
    btn_q <= cand_buttons;
    if (!reset) begin
      state_q      <= S_IDLE;
      arm_mask_q   <= '0;
      idx_q        <= '0;
      stable_cnt_q <= '0;
      need_rel_q   <= 1'b1;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q      <= '0;
      sat_q        <= '0;
      sel_q        <= '0;
      leds_q       <= '0;
      vote_valid_q <= 1'b0;
      vote_cand_q  <= '0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_mask_q   <= arm_mask_d;
      idx_q        <= idx_d;
      stable_cnt_q <= stable_cnt_d;
      need_rel_q   <= need_rel_d;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= cnt_d[i];
      total_q      <= total_d;
      sat_q        <= sat_d;
      sel_q        <= sel_d;
      leds_q       <= leds_d;
      vote_valid_q <= vote_valid_d;
      vote_cand_q  <= vote_cand_d;
      invalid_q    <= invalid_d;
    end
  end

  assign LEDs          = leds_q;
  assign vote_valid    = vote_valid_q;
  assign vote_cand     = vote_cand_q;
  assign invalid_press = invalid_q;
  assign sat           = sat_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_voting_machine_n.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_voting_machine_n                                                      |
// | Scoreboard bench for voting_machine_n (default and CNT_W=2 instances).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_voting_machine_n;

  localparam int D  = 10;
  localparam int D2 = 3;

  logic       clk = 1'b0;
  logic       reset, mode, show_total;
  logic [3:0] btn;
  logic [7:0] leds;
  logic       vv, inv, busy;
  logic [3:0] vc, sat;

  logic       mode2, show2;
  logic [3:0] btn2;
  logic [1:0] leds2;
  logic       vv2, inv2, busy2;
  logic [3:0] vc2, sat2;

  always #5 clk = ~clk;

  voting_machine_n dut (
    .clk(clk), .reset(reset), .mode(mode), .cand_buttons(btn), .show_total(show_total),
    .LEDs(leds), .vote_valid(vv), .vote_cand(vc), .invalid_press(inv), .sat(sat), .busy(busy)
  );

  voting_machine_n #(.NUM_CAND(4), .CNT_W(2), .DEBOUNCE(D2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode2), .cand_buttons(btn2), .show_total(show2),
    .LEDs(leds2), .vote_valid(vv2), .vote_cand(vc2), .invalid_press(inv2), .sat(sat2), .busy(busy2)
  );

  typedef struct {int inv; int cand; int cyc;} ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int v2_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every DUT event is matched against the next expected entry
  always @(negedge clk) begin : mon
    ev_t e;
    if (vv || inv) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event vote_valid=%0b invalid_press=%0b cand=%0d cyc=%0d",
                 vv, inv, vc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_invalid", {31'b0, inv}, e.inv);
        if (e.inv == 0) chk("vote_cand", {28'b0, vc}, e.cand);
        chk("event_cycle", cyc, e.cyc);
      end
    end
    if (vv2) v2_count <= v2_count + 1;
  end

  // exp: cand index for a vote, -1 for nothing, -2 for a rejected press
  task automatic press(input logic [3:0] mask, input int hold, input int exp);
    int c0;
    @(posedge clk); #1;
    btn = mask;
    c0  = cyc;
    if (exp >= 0)       exp_q.push_back('{0, exp, c0 + D + 2});
    else if (exp == -2) exp_q.push_back('{1, 0, c0 + 3});
    repeat (hold) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (4) @(posedge clk);
  endtask

  task automatic show(input logic [3:0] sel, input logic st, input int req, input string nm);
    @(posedge clk); #1;
    mode = 1'b1;
    btn = sel;
    show_total = st;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(nm, {24'b0, leds}, req);
    @(posedge clk); #1 btn = 4'b0000;
    repeat (3) @(posedge clk);
    #1 mode = 1'b0;
    show_total = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 reset = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic press2();
    @(posedge clk); #1 btn2 = 4'b1000;
    repeat (6) @(posedge clk);
    #1 btn2 = 4'b0000;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; show_total = 1'b0; btn = 4'b0000;
    mode2 = 1'b0; show2 = 1'b0; btn2 = 4'b0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_leds", {24'b0, leds}, 0);
    chk("rst_vote_valid", {31'b0, vv}, 0);
    chk("rst_vote_cand", {28'b0, vc}, 0);
    chk("rst_invalid", {31'b0, inv}, 0);
    chk("rst_sat", {28'b0, sat}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // single vote, held well past the debounce window
    press(4'b0001, 30, 0);
    show(4'b0001, 1'b0, 1, "leds_cand0_single");
    @(negedge clk);
    chk("leds_zero_voting_mode", {24'b0, leds}, 0);

    // glitch shorter than debounce, then a real press
    press(4'b0010, 5, -1);
    show(4'b0010, 1'b0, 0, "leds_cand1_after_glitch");
    press(4'b0010, 15, 1);
    show(4'b0010, 1'b0, 1, "leds_cand1_after_hold");

    // simultaneous press, then narrowing to one button without release
    begin
      int c0;
      @(posedge clk); #1 btn = 4'b0110;
      c0 = cyc;
      exp_q.push_back('{1, 0, c0 + 3});
      repeat (20) @(posedge clk);
      #1 btn = 4'b0010;
      repeat (20) @(posedge clk);
      #1 btn = 4'b0000;
      repeat (4) @(posedge clk);
    end
    show(4'b0010, 1'b0, 1, "leds_cand1_after_multi");
    show(4'b0100, 1'b0, 0, "leds_cand2_after_multi");

    // fresh vote sequence: cand0 x2, cand1 x1, cand2 x3
    do_reset(2);
    press(4'b0001, 12, 0);
    press(4'b0001, 12, 0);
    press(4'b0010, 12, 1);
    press(4'b0100, 12, 2);
    press(4'b0100, 12, 2);
    press(4'b0100, 12, 2);
    show(4'b0001, 1'b0, 2, "seq_leds_cand0");
    show(4'b0010, 1'b0, 1, "seq_leds_cand1");
    show(4'b0100, 1'b0, 3, "seq_leds_cand2");
    show(4'b1000, 1'b0, 0, "seq_leds_cand3");
    show(4'b0000, 1'b1, 6, "seq_leds_total");

    // display mode entered mid-debounce aborts the vote
    @(posedge clk); #1 btn = 4'b0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_during_arm", {31'b0, busy}, 1);
    repeat (3) @(posedge clk);
    #1 mode = 1'b1;
    repeat (10) @(posedge clk);
    #1 mode = 1'b0;
    repeat (20) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (4) @(posedge clk);
    show(4'b0100, 1'b0, 3, "abort_leds_cand2");

    // reset mid-debounce with the button still held afterwards
    @(posedge clk); #1 btn = 4'b0010;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_vote_valid", {31'b0, vv}, 0);
    chk("midrst_leds", {24'b0, leds}, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("held_after_reset_busy", {31'b0, busy}, 0);
    @(posedge clk); #1 btn = 4'b0000;
    repeat (4) @(posedge clk);
    show(4'b0010, 1'b0, 0, "leds_cand1_after_reset");
    press(4'b0010, 15, 1);
    show(4'b0010, 1'b0, 1, "leds_cand1_repress");
    show(4'b0000, 1'b1, 1, "leds_total_repress");

    // saturation on the narrow-counter instance
    repeat (3) press2();
    @(negedge clk);
    chk("sat2_after_3", {28'b0, sat2}, 0);
    chk("votes2_after_3", v2_count, 3);
    repeat (2) press2();
    @(negedge clk);
    chk("votes2_after_5", v2_count, 5);
    chk("sat2_after_5", {28'b0, sat2}, 4'b1000);
    chk("total2_after_5", {26'b0, dut2.total_q}, 5);
    @(posedge clk); #1 mode2 = 1'b1; btn2 = 4'b1000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("leds2_cand3", {30'b0, leds2}, 3);
    @(posedge clk); #1 show2 = 1'b1; btn2 = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("leds2_total_clamped", {30'b0, leds2}, 3);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
